// File: rtl/sine_taylor_iter_if.sv
// Argument/result handshake bundle for the iterative sin/cos engine.
// master = argument producer and result consumer side, slave = engine side.
interface sine_taylor_iter_if #(
  parameter int IN_W  = 12,
  parameter int OUT_W = 16
);
  logic [IN_W-1:0]  x;
  logic             mode;
  logic             arg_vld;
  logic             arg_rdy;
  logic [OUT_W-1:0] res;
  logic             res_vld;
  logic             res_rdy;
  logic             sat;
  logic             busy;

  modport master (
    output x, mode, arg_vld, res_rdy,
    input  arg_rdy, res, res_vld, sat, busy
  );

  modport slave (
    input  x, mode, arg_vld, res_rdy,
    output arg_rdy, res, res_vld, sat, busy
  );
endinterface

// File: rtl/sine_taylor_iter.sv
// Iterative fixed-point sin/cos engine: Horner evaluation of a TERMS-term Taylor series,
// one operation in flight, valid/ready on both sides, output clamped to [-1.0, +1.0].
module sine_taylor_iter #(
  parameter int IN_W     = 12,
  parameter int IN_FRAC  = 8,
  parameter int OUT_W    = 16,
  parameter int OUT_FRAC = 12,
  parameter int TERMS    = 4,
  parameter int GUARD    = 4
) (
  input  logic               clk_i,
  input  logic               srst_i,
  sine_taylor_iter_if.slave  bus_if
);

  localparam int IF = OUT_FRAC + GUARD;
  localparam int W  = 12 + IF;
  localparam int P  = 2 * W;
  localparam int CW = IF + 2;

  generate
    if (TERMS < 1 || TERMS > 8) begin : g_badTerms
      $error("sine_taylor_iter: TERMS must be within 1..8");
    end
    if (IF < IN_FRAC) begin : g_badFrac
      $error("sine_taylor_iter: internal fraction narrower than input fraction");
    end
  endgenerate

  // Series coefficient 1/den rounded to nearest at IF fractional bits.
  function automatic logic [CW-1:0] coef(input int k, input logic cosMode);
    longint den;
    longint one;
    den = cosMode ? longint'((2 * k - 1) * (2 * k)) : longint'((2 * k) * (2 * k + 1));
    one = longint'(1) <<< IF;
    return CW'((one + den / 2) / den);
  endfunction

  localparam logic [CW-1:0] SIN_C [8] = '{
    coef(1, 1'b0), coef(2, 1'b0), coef(3, 1'b0), coef(4, 1'b0),
    coef(5, 1'b0), coef(6, 1'b0), coef(7, 1'b0), coef(8, 1'b0)
  };
  localparam logic [CW-1:0] COS_C [8] = '{
    coef(1, 1'b1), coef(2, 1'b1), coef(3, 1'b1), coef(4, 1'b1),
    coef(5, 1'b1), coef(6, 1'b1), coef(7, 1'b1), coef(8, 1'b1)
  };

  localparam logic signed [W-1:0] ONE     = W'(1) <<< IF;
  localparam logic signed [W-1:0] HALF    = (GUARD > 0) ? (W'(1) <<< ((GUARD > 0) ? GUARD - 1 : 0)) : W'(0);
  localparam logic signed [W-1:0] POS_LIM = W'(1) <<< OUT_FRAC;
  localparam logic signed [W-1:0] NEG_LIM = -POS_LIM;

  typedef enum logic [2:0] {IDLE, SQR, ITER, FIN, DONE} state_t;

  state_t                   state_q;
  logic signed [IN_W-1:0]   x_q;
  logic                     mode_q;
  logic signed [W-1:0]      x2_q;
  logic signed [W-1:0]      r_q;
  logic [3:0]               k_q;
  logic [OUT_W-1:0]         res_q;
  logic                     resVld_q;
  logic                     sat_q;

  logic signed [W-1:0]      xF;
  logic signed [P-1:0]      sq;
  logic signed [W-1:0]      x2_d;
  logic [2:0]               kIdx;
  logic [CW-1:0]            cU;
  logic signed [W-1:0]      cS;
  logic signed [P-1:0]      prodXR;
  logic signed [W-1:0]      tXR;
  logic signed [P-1:0]      prodTC;
  logic signed [W-1:0]      r_d;
  logic signed [P-1:0]      prodY;
  logic signed [W-1:0]      y;
  logic signed [W-1:0]      yRnd;
  logic signed [W-1:0]      yClamp;
  logic [OUT_W-1:0]         res_d;
  logic                     sat_d;

  // Datapath for the current state: all shifts are arithmetic, i.e. floor truncation.
  always_comb begin
    xF     = W'(x_q) <<< (IF - IN_FRAC);
    sq     = P'(xF) * P'(xF);
    x2_d   = W'(sq >>> IF);

    kIdx   = 3'(k_q - 4'd1);
    cU     = mode_q ? COS_C[kIdx] : SIN_C[kIdx];
    cS     = W'(cU);
    prodXR = P'(x2_q) * P'(r_q);
    tXR    = W'(prodXR >>> IF);
    prodTC = P'(tXR) * P'(cS);
    r_d    = ONE - W'(prodTC >>> IF);

    prodY  = P'(xF) * P'(r_q);
    y      = mode_q ? r_q : W'(prodY >>> IF);
    yRnd   = (y + HALF) >>> GUARD;
    yClamp = yRnd;
    sat_d  = 1'b0;
    if (yRnd > POS_LIM) begin
      yClamp = POS_LIM;
      sat_d  = 1'b1;
    end else if (yRnd < NEG_LIM) begin
      yClamp = NEG_LIM;
      sat_d  = 1'b1;
    end
    res_d  = OUT_W'(yClamp);
  end

  // Control FSM; the result registers only change on the FIN->DONE edge.
  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      state_q  <= IDLE;
      x_q      <= '0;
      mode_q   <= 1'b0;
      x2_q     <= '0;
      r_q      <= '0;
      k_q      <= '0;
      res_q    <= '0;
      resVld_q <= 1'b0;
      sat_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus_if.arg_vld) begin
            x_q     <= bus_if.x;
            mode_q  <= bus_if.mode;
            r_q     <= ONE;
            state_q <= SQR;
          end
        end
        SQR: begin
          x2_q    <= x2_d;
          k_q     <= 4'(TERMS - 1);
          state_q <= (TERMS == 1) ? FIN : ITER;
        end
        ITER: begin
          r_q <= r_d;
          k_q <= k_q - 4'd1;
          if (k_q == 4'd1) begin
            state_q <= FIN;
          end
        end
        FIN: begin
          res_q    <= res_d;
          sat_q    <= sat_d;
          resVld_q <= 1'b1;
          state_q  <= DONE;
        end
        DONE: begin
          if (bus_if.res_rdy) begin
            resVld_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus_if.arg_rdy = (state_q == IDLE);
  assign bus_if.busy    = (state_q != IDLE);
  assign bus_if.res     = res_q;
  assign bus_if.res_vld = resVld_q;
  assign bus_if.sat     = sat_q;

endmodule

// File: tb/tb_sine_taylor_iter.sv
// Self-checking bench for sine_taylor_iter: directed corner cases plus random arguments,
// every result compared against a plain-arithmetic series model.
module tb_sine_taylor_iter;

  localparam int TERMS = 4;

  typedef struct {
    logic [15:0] res;
    logic        sat;
  } exp_t;

  logic clk = 1'b0;
  logic srst;

  int   testsRun    = 0;
  int   testsFailed = 0;
  int   cycCnt      = 0;
  int   acceptCyc   = 0;
  int   doneCnt     = 0;
  exp_t expQ[$];
  exp_t front;
  logic expVld;
  logic [15:0] lastRes;
  logic        lastSat;

  always #5 clk = ~clk;

  sine_taylor_iter_if #(.IN_W(12), .OUT_W(16)) bus ();

  sine_taylor_iter #(
    .IN_W(12), .IN_FRAC(8), .OUT_W(16), .OUT_FRAC(12), .TERMS(TERMS), .GUARD(4)
  ) dut (
    .clk_i  (clk),
    .srst_i (srst),
    .bus_if (bus.slave)
  );

  // Series model: Horner loop over the truncated Q.16 arithmetic, then round and clamp.
  function automatic exp_t modelOp(input logic [11:0] x, input logic m);
    longint xf, x2, r, t, d, c, y, yr;
    exp_t   e;
    xf = longint'($signed(x)) * 256;
    x2 = (xf * xf) >>> 16;
    r  = 65536;
    for (int k = TERMS - 1; k >= 1; k--) begin
      d = m ? longint'((2 * k - 1) * (2 * k)) : longint'((2 * k) * (2 * k + 1));
      c = (65536 + d / 2) / d;
      t = (x2 * r) >>> 16;
      r = 65536 - ((t * c) >>> 16);
    end
    y = m ? r : ((xf * r) >>> 16);
    yr = (y + 8) >>> 4;
    e.sat = 1'b0;
    if (yr > 4096) begin
      yr = 4096;
      e.sat = 1'b1;
    end else if (yr < -4096) begin
      yr = -4096;
      e.sat = 1'b1;
    end
    e.res = 16'(yr);
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkRange(input string name, input int actual, input int lo, input int hi);
    testsRun++;
    if (actual < lo || actual > hi) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, want %0d..%0d", name, actual, lo, hi);
    end
  endtask

  always @(posedge clk) cycCnt <= cycCnt + 1;

  // Per-cycle compare against the in-flight expectation queue.
  always @(negedge clk) begin
    if (srst) begin
      expQ.delete();
    end else begin
      checkOutput("argRdy", 32'(bus.arg_rdy), 32'(expQ.size() == 0));
      checkOutput("busy", 32'(bus.busy), 32'(expQ.size() != 0));
      expVld = (expQ.size() != 0) && (cycCnt - acceptCyc >= TERMS + 1);
      checkOutput("resVld", 32'(bus.res_vld), 32'(expVld));
      if (bus.res_vld && expQ.size() != 0) begin
        front = expQ[0];
        checkOutput("res", 32'(bus.res), 32'(front.res));
        checkOutput("sat", 32'(bus.sat), 32'(front.sat));
        if (bus.res_rdy) begin
          lastRes = bus.res;
          lastSat = bus.sat;
          void'(expQ.pop_front());
          doneCnt++;
        end
      end
      if (bus.arg_vld && bus.arg_rdy) begin
        expQ.push_back(modelOp(bus.x, bus.mode));
        acceptCyc = cycCnt + 1;
      end
    end
  end

  task automatic applyStimulus(input logic [11:0] x, input logic m, input int stall, input logic junk);
    int n;
    int startDone;
    startDone = doneCnt;
    @(posedge clk); #1;
    bus.x = x;
    bus.mode = m;
    bus.arg_vld = 1'b1;
    bus.res_rdy = (stall == 0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.arg_rdy && n < 50);
    if (n >= 50) checkOutput("acceptTimeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    bus.arg_vld = 1'b0;
    n = 0;
    while (!bus.res_vld && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) checkOutput("resultTimeout", 32'd0, 32'd1);
    if (stall > 0) begin
      @(posedge clk); #1;
      if (junk) begin
        bus.x = 12'($urandom);
        bus.mode = 1'($urandom);
        bus.arg_vld = 1'b1;
      end
      repeat (stall) @(negedge clk);
      @(posedge clk); #1;
      bus.arg_vld = 1'b0;
      bus.res_rdy = 1'b1;
    end
    n = 0;
    while (doneCnt == startDone && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) checkOutput("handshakeTimeout", 32'd0, 32'd1);
  endtask

  initial begin
    exp_t mp;
    logic signed [15:0] resPos;
    logic signed [15:0] resNeg;

    srst = 1'b1;
    bus.x = '0;
    bus.mode = 1'b0;
    bus.arg_vld = 1'b0;
    bus.res_rdy = 1'b1;

    mp = modelOp(12'h000, 1'b0);
    checkOutput("modelSin0", 32'(mp.res), 32'h0000);
    mp = modelOp(12'h000, 1'b1);
    checkOutput("modelCos0", 32'(mp.res), 32'h1000);
    mp = modelOp(12'h192, 1'b0);
    checkRange("modelSinHalfPi", int'(mp.res), 'h0FFD, 'h1000);
    mp = modelOp(12'hE6E, 1'b0);
    checkRange("modelSinNegHalfPi", int'($signed(mp.res)), -4096, -4093);
    mp = modelOp(12'h800, 1'b1);
    checkOutput("modelCosNeg8", {15'd0, mp.sat, mp.res}, {15'd0, 1'b1, 16'hF000});
    mp = modelOp(12'h100, 1'b0);
    checkRange("modelSin1", int'(mp.res), 'h0D74, 'h0D78);

    #1;
    checkOutput("rstRes", 32'(bus.res), 32'h0);
    checkOutput("rstResVld", 32'(bus.res_vld), 32'h0);
    checkOutput("rstSat", 32'(bus.sat), 32'h0);
    checkOutput("rstBusy", 32'(bus.busy), 32'h0);
    checkOutput("rstArgRdy", 32'(bus.arg_rdy), 32'h1);
    repeat (2) @(negedge clk);
    #2 srst = 1'b0;

    applyStimulus(12'h000, 1'b0, 0, 1'b0);
    checkOutput("sin0", {15'd0, lastSat, lastRes}, {15'd0, 1'b0, 16'h0000});
    applyStimulus(12'h000, 1'b1, 0, 1'b0);
    checkOutput("cos0", {15'd0, lastSat, lastRes}, {15'd0, 1'b0, 16'h1000});
    applyStimulus(12'h192, 1'b0, 0, 1'b0);
    resPos = lastRes;
    checkRange("sinHalfPi", int'(resPos), 'h0FFD, 'h1000);
    applyStimulus(12'hE6E, 1'b0, 0, 1'b0);
    resNeg = lastRes;
    checkRange("sinNegHalfPi", int'(resNeg), -4096, -4093);
    checkRange("sinSymmetry", int'(resPos) + int'(resNeg), -1, 1);
    applyStimulus(12'h800, 1'b1, 0, 1'b0);
    checkOutput("cosNeg8", {15'd0, lastSat, lastRes}, {15'd0, 1'b1, 16'hF000});
    applyStimulus(12'h7FF, 1'b0, 0, 1'b0);
    checkOutput("sinPos8Sat", 32'(lastSat), 32'h1);

    applyStimulus(12'($urandom), 1'b0, 6, 1'b1);

    for (int i = 0; i < 40; i++) begin
      applyStimulus(12'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
    end

    // Abort an operation in the middle of the Horner loop.
    @(posedge clk); #1;
    bus.x = 12'h5A5;
    bus.mode = 1'b0;
    bus.arg_vld = 1'b1;
    bus.res_rdy = 1'b1;
    @(posedge clk); #1;
    bus.arg_vld = 1'b0;
    @(posedge clk);
    @(posedge clk); #3;
    srst = 1'b1;
    #1;
    checkOutput("abortResVld", 32'(bus.res_vld), 32'h0);
    checkOutput("abortArgRdy", 32'(bus.arg_rdy), 32'h1);
    checkOutput("abortBusy", 32'(bus.busy), 32'h0);
    @(negedge clk);
    #2 srst = 1'b0;

    applyStimulus(12'h100, 1'b0, 0, 1'b0);
    checkRange("sin1AfterAbort", int'(lastRes), 'h0D74, 'h0D78);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
